inst_prefetch_buffer: RTL
=========================

INST_PREFETCH_BUFFER -- requirements
Module: inst_prefetch_buffer

Interface
REQ-001 The block SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 The block SHALL have port proc_reset, input, 1 bit: reset, asynchronous, active-high.
REQ-003 The block SHALL have port cache_read, input, 1 bit: I-cache block read request, held until cache_ready.
REQ-004 The block SHALL have port cache_write, input, 1 bit: I-cache block write request, held until cache_ready.
REQ-005 The block SHALL have port cache_addr, input, 28 bits: block address, byte address bits [31:4].
REQ-006 The block SHALL have port cache_wdata, input, 128 bits: write block data.
REQ-007 The block SHALL have port cache_rdata, output, 128 bits: read block data, valid while cache_ready=1.
REQ-008 The block SHALL have port cache_ready, output, 1 bit: one-cycle completion pulse to the I-cache.
REQ-009 The block SHALL have port mem_read, output, 1 bit: slow-memory read request, held until mem_ready.
REQ-010 The block SHALL have port mem_write, output, 1 bit: slow-memory write request, held until mem_ready.
REQ-011 The block SHALL have port mem_addr, output, 28 bits: slow-memory block address.
REQ-012 The block SHALL have port mem_wdata, output, 128 bits: slow-memory write data.
REQ-013 The block SHALL have port mem_rdata, input, 128 bits: slow-memory read data, valid with mem_ready.
REQ-014 The block SHALL have port mem_ready, input, 1 bit: one-cycle slow-memory completion pulse.

Function
REQ-015 The block SHALL hold one prefetch entry: buf_valid, buf_addr[27:0], buf_data[127:0].
REQ-016 The block SHALL implement FSM states IDLE, HIT, FETCH, WRITE, PREFETCH.
REQ-017 In IDLE, a request with cache_write=1 SHALL take priority over cache_read and SHALL move the FSM to WRITE.
REQ-018 In IDLE, cache_read=1 with buf_valid=1 and buf_addr=cache_addr SHALL move the FSM to HIT.
REQ-019 In IDLE, any other cache_read=1 SHALL move the FSM to FETCH.
REQ-020 In HIT, cache_ready SHALL be 1 and cache_rdata SHALL equal buf_data (hit latency = 2 cycles from the request being seen in IDLE); the FSM SHALL then go to PREFETCH with pf_addr = buf_addr+1.
REQ-021 In FETCH, mem_read SHALL be 1 and mem_addr SHALL equal cache_addr.
REQ-022 On mem_ready in FETCH, cache_ready SHALL be 1 in the same cycle with cache_rdata=mem_rdata (combinational pass-through), and the FSM SHALL go to PREFETCH with pf_addr = cache_addr+1.
REQ-023 In WRITE, mem_write=1, mem_addr=cache_addr and mem_wdata=cache_wdata SHALL be driven.
REQ-024 On mem_ready in WRITE, cache_ready SHALL be 1 for that cycle; if buf_addr=cache_addr, buf_valid SHALL be cleared; the FSM SHALL return to IDLE.
REQ-025 In PREFETCH, mem_read=1 and mem_addr=pf_addr SHALL be driven; on mem_ready, buf_data, buf_addr and buf_valid SHALL be loaded with mem_rdata, pf_addr and 1.
REQ-026 If cache_read=1 with cache_addr=pf_addr coincides with mem_ready in PREFETCH, cache_ready SHALL pulse with cache_rdata=mem_rdata in that cycle and the FSM SHALL re-enter PREFETCH with pf_addr+1.
REQ-027 Any other cache request arriving during PREFETCH SHALL wait; an in-flight memory access SHALL never be aborted or re-addressed; on completion the FSM SHALL go to IDLE and serve the request from there.
REQ-028 pf_addr increment SHALL be modulo 2^28 (0xFFFFFFF+1 = 0x0000000).
REQ-029 In the cycle after any cache_ready pulse, the block SHALL ignore cache_read and cache_write (one-cycle turnaround) and SHALL remain in or return to IDLE.
REQ-030 mem_read and mem_write SHALL never be 1 simultaneously; the outputs SHALL be 0 and mem_addr, mem_wdata and cache_rdata SHALL be 0 whenever not specified above.

Reset
REQ-031 While proc_reset=1, the FSM SHALL be IDLE, buf_valid=0, buf_addr=0, buf_data=0, pf_addr=0, and all outputs SHALL be 0.
REQ-032 Asserting reset mid-transaction SHALL drop the transaction and SHALL not generate a cache_ready pulse.

Configuration
REQ-033 With macro IPF_PREFETCH_EN defined, the block SHALL behave per REQ-015..REQ-030.
REQ-034 With IPF_PREFETCH_EN undefined, the PREFETCH and HIT states and the buffer SHALL be absent; after FETCH/WRITE the FSM SHALL return to IDLE, and the block SHALL act as a pass-through with identical port behaviour.

Verification
REQ-035 Read 0x0000010 on a cold buffer, mem latency 4 -> FETCH, cache_ready at mem_ready, then a mem_read at 0x0000011 and buf_valid=1.
REQ-036 Read 0x0000010, then read 0x0000011 after the prefetch completes -> no memory request for 0x0000011; cache_ready 2 cycles after the request with the prefetched data.
REQ-037 Read 0x0000011 while the prefetch of 0x0000011 is in flight -> cache_ready coincides with mem_ready, followed by a prefetch at 0x0000012.
REQ-038 Read 0x0000050 while the prefetch of 0x0000011 is in flight -> the prefetch completes first, then FETCH at 0x0000050; mem_addr is never changed mid-request.
REQ-039 Write to 0x0000011 while buf_addr=0x0000011 -> mem_write pulse completes and buf_valid=0; a following read of 0x0000011 goes to FETCH.
REQ-040 Read 0xFFFFFFF -> prefetch address 0x0000000; reset asserted during the prefetch -> all outputs 0 and buf_valid=0 immediately.

Source files
------------

// File: rtl/inst_prefetch_buffer_if.sv
// Block-transfer buses between I-cache, prefetch buffer and slow memory.
// slave: the prefetch buffer's view; master: the I-cache/memory environment.
interface inst_prefetch_buffer_if;
    logic         cache_read;
    logic         cache_write;
    logic [27:0]  cache_addr;
    logic [127:0] cache_wdata;
    logic [127:0] cache_rdata;
    logic         cache_ready;
    logic         mem_read;
    logic         mem_write;
    logic [27:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ready;

    modport slave (
        input  cache_read,
        input  cache_write,
        input  cache_addr,
        input  cache_wdata,
        output cache_rdata,
        output cache_ready,
        output mem_read,
        output mem_write,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ready
    );

    modport master (
        output cache_read,
        output cache_write,
        output cache_addr,
        output cache_wdata,
        input  cache_rdata,
        input  cache_ready,
        input  mem_read,
        input  mem_write,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ready
    );
endinterface

// File: rtl/inst_prefetch_buffer.sv
// Single-entry next-block instruction prefetcher between I-cache and slow memory.
// Define IPF_PREFETCH_EN to enable the prefetch buffer; otherwise pure pass-through.
module inst_prefetch_buffer (
    input  logic                  clk,
    input  logic                  proc_reset,
    inst_prefetch_buffer_if.slave bus
);

`ifdef IPF_PREFETCH_EN
    typedef enum logic [2:0] {
        IDLE,
        HIT,
        FETCH,
        WRITE,
        PREFETCH
    } state_t;
`else
    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        WRITE
    } state_t;
`endif

    state_t state;
    state_t state_nxt;

    // Set in the cycle after cache_ready; requests are not sampled then.
    logic turn;
    logic rd_req;
    logic wr_req;
    logic rd_go;

    assign wr_req = bus.cache_write & ~turn;
    assign rd_req = bus.cache_read & ~turn;
    assign rd_go  = rd_req & ~wr_req;

`ifdef IPF_PREFETCH_EN
    logic         buf_valid;
    logic [27:0]  buf_addr;
    logic [127:0] buf_data;
    logic [27:0]  pf_addr;
    logic [27:0]  pf_addr_nxt;
    logic         pf_load;
    logic         buf_load;
    logic         buf_inval;
    logic         buf_hit;
    logic         pf_hit;

    assign buf_hit = buf_valid & (buf_addr == bus.cache_addr);
    assign pf_hit  = rd_go & (bus.cache_addr == pf_addr);
`endif

    // State register and one-cycle turnaround flag
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            state <= IDLE;
            turn  <= 1'b0;
        end else begin
            state <= state_nxt;
            turn  <= bus.cache_ready;
        end
    end

`ifdef IPF_PREFETCH_EN
    // Prefetch entry and the address of the next block to prefetch
    always_ff @(posedge clk or posedge proc_reset) begin
        if (proc_reset) begin
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            pf_addr   <= '0;
        end else begin
            if (pf_load) begin
                pf_addr <= pf_addr_nxt;
            end
            if (buf_load) begin
                buf_valid <= 1'b1;
                buf_addr  <= pf_addr;
                buf_data  <= bus.mem_rdata;
            end else if (buf_inval) begin
                buf_valid <= 1'b0;
            end
        end
    end
`endif

    // Next state and all bus outputs; idle outputs are zero
    always_comb begin
        state_nxt       = state;
        bus.cache_ready = 1'b0;
        bus.cache_rdata = '0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.mem_addr    = '0;
        bus.mem_wdata   = '0;
`ifdef IPF_PREFETCH_EN
        pf_load     = 1'b0;
        pf_addr_nxt = pf_addr;
        buf_load    = 1'b0;
        buf_inval   = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                unique case (1'b1)
                    wr_req: begin
                        state_nxt = WRITE;
                    end
`ifdef IPF_PREFETCH_EN
                    rd_go && buf_hit: begin
                        state_nxt = HIT;
                    end
                    rd_go && !buf_hit: begin
                        state_nxt = FETCH;
                    end
`else
                    rd_go: begin
                        state_nxt = FETCH;
                    end
`endif
                    default: begin
                        state_nxt = IDLE;
                    end
                endcase
            end
`ifdef IPF_PREFETCH_EN
            HIT: begin
                bus.cache_ready = 1'b1;
                bus.cache_rdata = buf_data;
                pf_load         = 1'b1;
                pf_addr_nxt     = buf_addr + 28'd1;
                state_nxt       = PREFETCH;
            end
`endif
            FETCH: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = bus.cache_addr;
                if (bus.mem_ready) begin
                    bus.cache_ready = 1'b1;
                    bus.cache_rdata = bus.mem_rdata;
`ifdef IPF_PREFETCH_EN
                    pf_load     = 1'b1;
                    pf_addr_nxt = bus.cache_addr + 28'd1;
                    state_nxt   = PREFETCH;
`else
                    state_nxt   = IDLE;
`endif
                end
            end
            WRITE: begin
                bus.mem_write = 1'b1;
                bus.mem_addr  = bus.cache_addr;
                bus.mem_wdata = bus.cache_wdata;
                if (bus.mem_ready) begin
                    bus.cache_ready = 1'b1;
`ifdef IPF_PREFETCH_EN
                    buf_inval = buf_hit;
`endif
                    state_nxt = IDLE;
                end
            end
`ifdef IPF_PREFETCH_EN
            PREFETCH: begin
                bus.mem_read = 1'b1;
                bus.mem_addr = pf_addr;
                if (bus.mem_ready) begin
                    buf_load = 1'b1;
                    if (pf_hit) begin
                        bus.cache_ready = 1'b1;
                        bus.cache_rdata = bus.mem_rdata;
                        pf_load         = 1'b1;
                        pf_addr_nxt     = pf_addr + 28'd1;
                        state_nxt       = PREFETCH;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
`endif
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule
